// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and helpers, used by conv_window_gen and conv_calc.
package cnn_pkg;

  localparam int FILTER_SIZE = 5;
  localparam int DATA_BITS   = 8;
  localparam int IMG_WIDTH   = 28;
  localparam int IMG_HEIGHT  = 28;

  localparam int COL_W     = $clog2(IMG_WIDTH);
  localparam int ROW_W     = $clog2(IMG_HEIGHT);
  localparam int WIN_ELEMS = FILTER_SIZE * FILTER_SIZE;
  localparam int WIN_BITS  = WIN_ELEMS * DATA_BITS;

  // Flat window index: row r (0 = oldest/top), column c (0 = leftmost).
  function automatic int win_idx(input int r, input int c, input int fs = FILTER_SIZE);
    return r * fs + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image-row delay: circular buffer addressed by column, read-before-write at the same address.
module line_buffer #(
  parameter int DEPTH     = 28,
  parameter int DATA_BITS = 8,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Asynchronous read returns the pixel written one row ago, before this cycle's write lands.
  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming FILTER_SIZE x FILTER_SIZE sliding-window generator feeding conv_calc (valid positions only).
module conv_window_gen #(
  parameter int FILTER_SIZE = cnn_pkg::FILTER_SIZE,
  parameter int DATA_BITS   = cnn_pkg::DATA_BITS,
  parameter int IMG_WIDTH   = cnn_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT  = cnn_pkg::IMG_HEIGHT
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_val,
  input  logic [DATA_BITS-1:0]                     pix_in,
  output logic                                     out_val,
  output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] window,
  output logic                                     frame_done
);

  import cnn_pkg::win_idx;

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int NE    = FILTER_SIZE * FILTER_SIZE;
  localparam int LB_N  = FILTER_SIZE - 1;

  logic [COL_W-1:0]     col_p0;
  logic [ROW_W-1:0]     row_p0;
  logic                 col_last_p0;
  logic                 row_last_p0;
  logic                 run_p0;
  logic                 emit_p0;
  logic                 done_p0;

  logic [DATA_BITS-1:0] lb_din   [LB_N];
  logic [DATA_BITS-1:0] lb_dout  [LB_N];
  logic [DATA_BITS-1:0] new_col  [FILTER_SIZE];

  logic [DATA_BITS-1:0] win_p1   [NE];
  logic                 vld_p1;
  logic                 done_p1;

  // ---- stage p0: position counters, phase decode, line buffers ----
  assign col_last_p0 = (col_p0 == COL_W'(IMG_WIDTH - 1));
  assign row_last_p0 = (row_p0 == ROW_W'(IMG_HEIGHT - 1));
  assign run_p0      = (row_p0 >= ROW_W'(FILTER_SIZE - 1));
  assign emit_p0     = in_val && run_p0 && (col_p0 >= COL_W'(FILTER_SIZE - 1));
  assign done_p0     = in_val && row_last_p0 && col_last_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (in_val) begin
      if (col_last_p0) begin
        col_p0 <= '0;
        row_p0 <= row_last_p0 ? '0 : row_p0 + ROW_W'(1);
      end else begin
        col_p0 <= col_p0 + COL_W'(1);
      end
    end
  end

  // Rows cascade upward: each buffer takes the next-younger row, the last one takes the live pixel.
  genvar k;
  generate
    for (k = 0; k < LB_N; k++) begin : g_lb
      if (k == LB_N - 1) begin : g_top
        assign lb_din[k] = pix_in;
      end else begin : g_mid
        assign lb_din[k] = lb_dout[k + 1];
      end

      line_buffer #(
        .DEPTH     (IMG_WIDTH),
        .DATA_BITS (DATA_BITS),
        .ADDR_W    (COL_W)
      ) u_line_buffer (
        .clk   (clk),
        .wr_en (in_val),
        .addr  (col_p0),
        .din   (lb_din[k]),
        .dout  (lb_dout[k])
      );

      assign new_col[k] = lb_dout[k];
    end
  endgenerate

  assign new_col[LB_N] = pix_in;

  // ---- stage p1: window shift register and output strobes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) begin
        win_p1[i] <= '0;
      end
    end else if (in_val) begin
      for (int r = 0; r < FILTER_SIZE; r++) begin
        for (int c = 0; c < FILTER_SIZE - 1; c++) begin
          win_p1[win_idx(r, c, FILTER_SIZE)] <= win_p1[win_idx(r, c + 1, FILTER_SIZE)];
        end
        win_p1[win_idx(r, FILTER_SIZE - 1, FILTER_SIZE)] <= new_col[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= emit_p0;
      done_p1 <= done_p0;
    end
  end

  always_comb begin
    window = '0;
    for (int i = 0; i < NE; i++) begin
      window[i*DATA_BITS +: DATA_BITS] = win_p1[i];
    end
  end

  assign out_val    = vld_p1;
  assign frame_done = done_p1;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed-random bench for conv_window_gen against an image-array reference model.
module tb_conv_window_gen;
  import cnn_pkg::*;

  localparam int F   = FILTER_SIZE;
  localparam int W   = IMG_WIDTH;
  localparam int H   = IMG_HEIGHT;
  localparam int DB  = DATA_BITS;
  localparam int NE  = F * F;
  localparam int WW  = NE * DB;
  localparam int WPF = (W - F + 1) * (H - F + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_val;
  logic [DB-1:0] pix_in;
  logic          out_val;
  logic [WW-1:0] window;
  logic          frame_done;

  always #5 clk = ~clk;

  conv_window_gen dut (
    .clk        (clk),
    .rst        (rst),
    .in_val     (in_val),
    .pix_in     (pix_in),
    .out_val    (out_val),
    .window     (window),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;

  int            mrow, mcol, mwin;
  logic [DB-1:0] img [H][W];
  int            nwin, ndone, nacc, first_acc;
  logic [WW-1:0] first_win, second_first, prev_win, w64;
  logic [WW-1:0] ref_seq [WPF];
  logic          v63;
  bit            record, compare_seq;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stats_reset();
    nwin = 0; ndone = 0; nacc = 0; mwin = 0; first_acc = -1;
  endtask

  function automatic logic [WW-1:0] elem(input logic [WW-1:0] w, input int i);
    return WW'(w[i*DB +: DB]);
  endfunction

  task automatic step(input logic v, input logic [DB-1:0] p);
    logic          ev;
    logic          ed;
    logic [WW-1:0] ew;
    in_val = v; pix_in = p; rst = 1'b0;
    @(posedge clk); #1;
    ev = 1'b0; ed = 1'b0; ew = '0;
    if (v) begin
      img[mrow][mcol] = p;
      nacc++;
      ev = (mrow >= F - 1) && (mcol >= F - 1);
      ed = (mrow == H - 1) && (mcol == W - 1);
      if (ev)
        for (int r = 0; r < F; r++)
          for (int c = 0; c < F; c++)
            ew[(r*F + c)*DB +: DB] = img[mrow - F + 1 + r][mcol - F + 1 + c];
      if (mrow == 6 && mcol == 3) v63 = out_val;
      if (mrow == 6 && mcol == 4) w64 = window;
      mcol++;
      if (mcol == W) begin
        mcol = 0; mrow++;
        if (mrow == H) mrow = 0;
      end
    end
    chk("out_val", WW'(out_val), WW'(ev));
    chk("frame_done", WW'(frame_done), WW'(ed));
    if (ev) begin
      chk("window", window, ew);
      if (record) ref_seq[mwin % WPF] = ew;
      if (compare_seq) chk("window_seq", window, ref_seq[mwin % WPF]);
      mwin++;
    end
    if (out_val) begin
      if (nwin == 0) begin first_acc = nacc; first_win = window; end
      if (nwin == WPF) second_first = window;
      nwin++;
    end
    if (frame_done) ndone++;
    if (!v) chk("window_hold", window, prev_win);
    prev_win = window;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_val = 1'b0; pix_in = '0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_out_val", WW'(out_val), '0);
      chk("rst_frame_done", WW'(frame_done), '0);
      chk("rst_window", window, '0);
    end
    rst = 1'b0;
    mrow = 0; mcol = 0;
    prev_win = '0;
  endtask

  task automatic run_frame(input int gap_pct, input int mode);
    logic [DB-1:0] p;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++)
          step(1'b0, DB'($urandom));
        p = (mode == 0) ? DB'((r*W + c) % 256) : DB'(mode);
        step(1'b1, p);
      end
    end
  endtask

  initial begin
    record = 0; compare_seq = 0; v63 = 1'bx; w64 = 'x;
    stats_reset();

    // Reset, then idle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'hA5);
      chk("idle_window_zero", window, '0);
    end

    // Ramp frame
    stats_reset(); record = 1;
    run_frame(0, 0);
    record = 0;
    chk("first_win_acc", WW'(first_acc), WW'(117));
    chk("first_e0", elem(first_win, 0), WW'(8'h00));
    chk("first_e4", elem(first_win, 4), WW'(8'h04));
    chk("first_e20", elem(first_win, 20), WW'(8'h70));
    chk("first_e24", elem(first_win, 24), WW'(8'h74));
    chk("ramp_count", WW'(nwin), WW'(WPF));
    chk("ramp_done", WW'(ndone), WW'(1));
    chk("wrap_no_win_63", WW'(v63), '0);
    chk("wrap_w64_e0", elem(w64, 0), WW'(56));
    chk("wrap_w64_e24", elem(w64, 24), WW'(172));

    // Gapped frame
    stats_reset(); compare_seq = 1;
    run_frame(40, 0);
    compare_seq = 0;
    chk("gap_count", WW'(nwin), WW'(WPF));
    chk("gap_done", WW'(ndone), WW'(1));

    // Reset mid-frame
    for (int i = 0; i < 10*W + 11; i++) step(1'b1, 8'hFF);
    do_reset();
    stats_reset();
    run_frame(0, 1);
    chk("mid_rst_first_acc", WW'(first_acc), WW'(117));
    chk("mid_rst_first_win", first_win, {NE{8'h01}});
    chk("mid_rst_count", WW'(nwin), WW'(WPF));

    // Back-to-back frames
    stats_reset();
    run_frame(0, 0);
    run_frame(0, 0);
    step(1'b0, 8'h00);
    chk("b2b_count", WW'(nwin), WW'(2*WPF));
    chk("b2b_done", WW'(ndone), WW'(2));
    chk("b2b_first_f1", first_win, ref_seq[0]);
    chk("b2b_first_f2", second_first, ref_seq[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
